// File: rtl/shift_iter.sv
// shift_iter: multi-cycle SLL/SRL/SRA unit that moves up to STEP bit positions per busy cycle.
// Optional macro SHIFT_ITER_ROT_EN adds Zbb ROL/ROR (funct7 = 0110000).
module shift_iter #(
    parameter int XLEN = 32,
    parameter int STEP = 8
) (
    input  logic            clk_i,
    input  logic            rst_n_i,
    input  logic            flush_i,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [2:0]      funct3_i,
    input  logic [6:0]      funct7_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [XLEN-1:0] res_o,
    output logic            err_o
);
    localparam int SHW = $clog2(XLEN);
    localparam logic [SHW:0] STEP_W = (SHW+1)'(STEP);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;
    typedef enum logic [2:0] {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR, OP_ILL} op_e;

    state_e            state_q, state_d;
    op_e               op_q, op_d, dec_op;
    logic [XLEN-1:0]   data_q, data_d;
    logic [SHW-1:0]    rem_q, rem_d;
    logic              sign_q, sign_d;
    logic              err_q, err_d;

    logic [SHW-1:0]    shamt;
    logic [SHW-1:0]    k;
    logic [XLEN-1:0]   shifted;
    logic [2*XLEN-1:0] wide;
    logic [2*XLEN-1:0] wide_sh;
    logic              accept;
    logic              unused_op2;

    assign shamt       = op2_i[SHW-1:0];
    assign unused_op2  = ^op2_i[XLEN-1:SHW];
    assign in_ready_o  = (state_q == S_IDLE) || ((state_q == S_DONE) && out_ready_i);
    assign out_valid_o = (state_q == S_DONE);
    assign res_o       = data_q;
    assign err_o       = err_q;

    always_comb begin
        dec_op = OP_ILL;
        if (funct3_i == 3'b001 && funct7_i == 7'b0000000) begin
            dec_op = OP_SLL;
        end else if (funct3_i == 3'b101 && funct7_i == 7'b0000000) begin
            dec_op = OP_SRL;
        end else if (funct3_i == 3'b101 && funct7_i == 7'b0100000) begin
            dec_op = OP_SRA;
`ifdef SHIFT_ITER_ROT_EN
        end else if (funct3_i == 3'b001 && funct7_i == 7'b0110000) begin
            dec_op = OP_ROL;
        end else if (funct3_i == 3'b101 && funct7_i == 7'b0110000) begin
            dec_op = OP_ROR;
`endif
        end
    end

    // One iteration step: k = min(remaining, STEP), applied with the op's fill rule.
    always_comb begin
        if ({1'b0, rem_q} > STEP_W) begin
            k = STEP_W[SHW-1:0];
        end else begin
            k = rem_q;
        end
        wide    = {data_q, data_q};
        wide_sh = '0;
        shifted = data_q;
        case (op_q)
            OP_SLL: shifted = data_q << k;
            OP_SRL: shifted = data_q >> k;
            OP_SRA: begin
                wide_sh = {{XLEN{sign_q}}, data_q} >> k;
                shifted = wide_sh[XLEN-1:0];
            end
            OP_ROL: begin
                wide_sh = wide << k;
                shifted = wide_sh[2*XLEN-1:XLEN];
            end
            OP_ROR: begin
                wide_sh = wide >> k;
                shifted = wide_sh[XLEN-1:0];
            end
            default: shifted = data_q;
        endcase
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        data_d  = data_q;
        rem_d   = rem_q;
        sign_d  = sign_q;
        err_d   = err_q;
        accept  = in_valid_i && in_ready_o && !flush_i;
        if (flush_i) begin
            state_d = S_IDLE;
            err_d   = 1'b0;
            rem_d   = '0;
        end else begin
            case (state_q)
                S_BUSY: begin
                    data_d = shifted;
                    rem_d  = rem_q - k;
                    if (rem_q == k) begin
                        state_d = S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready_i) begin
                        state_d = S_IDLE;
                    end
                end
                default: begin
                end
            endcase
            // A new request overrides the DONE->IDLE return, giving back-to-back issue.
            if (accept) begin
                op_d   = dec_op;
                sign_d = op1_i[XLEN-1];
                if (dec_op == OP_ILL) begin
                    data_d  = '0;
                    rem_d   = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    data_d  = op1_i;
                    rem_d   = shamt;
                    err_d   = 1'b0;
                    state_d = (shamt == '0) ? S_DONE : S_BUSY;
                end
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            op_q    <= OP_SLL;
            data_q  <= '0;
            rem_q   <= '0;
            sign_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
            sign_q  <= sign_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_shift_iter.sv
// tb_shift_iter: scoreboard bench for shift_iter with a behavioural shift model.
// Rotate expectations follow SHIFT_ITER_ROT_EN when it is defined.
module tb_shift_iter;
    localparam int XLEN = 32;
    localparam int STEP = 8;

    typedef struct {
        logic [31:0] res;
        logic        err;
        int          accCyc;
        int          lat;
    } expT;

    expT         expQ[$];
    logic        clk = 1'b0;
    logic        rstN = 1'b0;
    logic        flush = 1'b0;
    logic        inValid = 1'b0;
    logic        fixedReady = 1'b1;
    logic        randomReady = 1'b0;
    logic        outReady;
    logic [2:0]  funct3 = 3'b000;
    logic [6:0]  funct7 = 7'b0000000;
    logic [31:0] op1 = '0;
    logic [31:0] op2 = '0;
    logic        inReady;
    logic        outValid;
    logic [31:0] res;
    logic        err;
    int          cyc = 0;
    int          compared = 0;
    int          mismatched = 0;
    bit          seen = 0;

    shift_iter #(.XLEN(XLEN), .STEP(STEP)) dut (
        .clk_i       (clk),
        .rst_n_i     (rstN),
        .flush_i     (flush),
        .in_valid_i  (inValid),
        .in_ready_o  (inReady),
        .funct3_i    (funct3),
        .funct7_i    (funct7),
        .op1_i       (op1),
        .op2_i       (op2),
        .out_valid_o (outValid),
        .out_ready_i (outReady),
        .res_o       (res),
        .err_o       (err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always begin
        outReady = randomReady ? 1'($urandom_range(0, 1)) : fixedReady;
        @(posedge clk);
        #2;
    end

    // Reference behaviour straight from the shift rules: plain operators and a latency formula.
    function automatic void model(input logic [2:0] f3, input logic [6:0] f7,
                                  input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic e, output int lat);
        int sh;
        sh = int'(b[4:0]);
        r  = '0;
        e  = 1'b0;
        if (f3 == 3'b001 && f7 == 7'h00) r = a << sh;
        else if (f3 == 3'b101 && f7 == 7'h00) r = a >> sh;
        else if (f3 == 3'b101 && f7 == 7'h20) r = $unsigned($signed(a) >>> sh);
`ifdef SHIFT_ITER_ROT_EN
        else if (f3 == 3'b001 && f7 == 7'h30) r = (sh == 0) ? a : ((a << sh) | (a >> (32 - sh)));
        else if (f3 == 3'b101 && f7 == 7'h30) r = (sh == 0) ? a : ((a >> sh) | (a << (32 - sh)));
`endif
        else e = 1'b1;
        lat = e ? 1 : 1 + (sh + STEP - 1) / STEP;
    endfunction

    task automatic checkValue(input string name, input logic [31:0] act, input logic [31:0] expv);
        compared++;
        if (act !== expv) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, expv);
        end
    endtask

    task automatic checkOutput();
        expT e;
        compared++;
        if (expQ.size() == 0) begin
            mismatched++;
            $display("[TB] FAIL unexpected_valid: out_valid high at cycle %0d with nothing in flight", cyc);
        end else begin
            e = expQ[0];
            if (!seen) begin
                compared++;
                if (cyc - e.accCyc != e.lat) begin
                    mismatched++;
                    $display("[TB] FAIL latency: got %0d expected %0d", cyc - e.accCyc, e.lat);
                end
                seen = 1;
            end
            compared++;
            if (res !== e.res || err !== e.err) begin
                mismatched++;
                $display("[TB] FAIL result: got res=0x%08h err=%0b expected res=0x%08h err=%0b",
                         res, err, e.res, e.err);
            end
            if (outReady) begin
                void'(expQ.pop_front());
                seen = 0;
            end
        end
    endtask

    // Monitor: retire the presented result first, then record any request accepted this cycle.
    always @(negedge clk) begin
        expT e;
        if (!rstN || flush) begin
            expQ.delete();
            seen = 0;
        end else begin
            if (outValid) checkOutput();
            if (inValid && inReady) begin
                model(funct3, funct7, op1, op2, e.res, e.err, e.lat);
                e.accCyc = cyc;
                expQ.push_back(e);
            end
        end
    end

    task automatic applyStimulus(input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [31:0] a, input logic [31:0] b, output int tries);
        bit done;
        done   = 0;
        tries  = 0;
        funct3 = f3;
        funct7 = f7;
        op1    = a;
        op2    = b;
        inValid = 1'b1;
        for (int i = 0; i < 200 && !done; i++) begin
            @(negedge clk);
            tries++;
            if (inReady) done = 1;
            @(posedge clk);
            #1;
        end
        inValid = 1'b0;
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL accept_timeout: request never accepted");
        end
    endtask

    task automatic idleCycles(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic waitDrain();
        bit done;
        done = 0;
        for (int i = 0; i < 500 && !done; i++) begin
            @(negedge clk);
            if (expQ.size() == 0) done = 1;
            @(posedge clk);
            #1;
        end
        if (!done) begin
            compared++;
            mismatched++;
            $display("[TB] FAIL drain_timeout: %0d results outstanding", expQ.size());
        end
    endtask

    initial begin
        int  tries;
        bit  gotValid;
        logic [2:0] f3;
        logic [6:0] f7;

        repeat (3) @(posedge clk);
        #1;
        rstN = 1'b1;
        @(negedge clk);
        checkValue("reset_in_ready", {31'd0, inReady}, 32'd1);
        checkValue("reset_out_valid", {31'd0, outValid}, 32'd0);
        checkValue("reset_res", res, 32'd0);
        checkValue("reset_err", {31'd0, err}, 32'd0);
        @(posedge clk);
        #1;

        applyStimulus(3'b001, 7'h00, 32'h0000_0001, 32'd31, tries);
        applyStimulus(3'b101, 7'h20, 32'h8000_0000, 32'd4, tries);
        applyStimulus(3'b101, 7'h00, 32'h8000_0000, 32'd4, tries);
        applyStimulus(3'b101, 7'h00, 32'hDEAD_BEEF, 32'h0000_0020, tries);
        waitDrain();

        // Result held with out_ready low, then handshake and new accept in one cycle.
        fixedReady = 1'b0;
        applyStimulus(3'b001, 7'h00, 32'h0000_00A5, 32'd3, tries);
        gotValid = 0;
        for (int i = 0; i < 50 && !gotValid; i++) begin
            @(negedge clk);
            if (outValid) gotValid = 1;
            @(posedge clk);
            #1;
        end
        checkValue("hold_valid_seen", {31'd0, gotValid}, 32'd1);
        idleCycles(2);
        fixedReady = 1'b1;
        applyStimulus(3'b101, 7'h20, 32'h8000_1234, 32'd9, tries);
        checkValue("no_bubble_tries", tries, 32'd1);
        waitDrain();

        applyStimulus(3'b001, 7'h00, 32'h1357_9BDF, 32'd20, tries);
        @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        @(negedge clk);
        checkValue("flush_in_ready", {31'd0, inReady}, 32'd1);
        checkValue("flush_out_valid", {31'd0, outValid}, 32'd0);
        @(posedge clk);
        #1;
        idleCycles(6);
        applyStimulus(3'b001, 7'h00, 32'h1357_9BDF, 32'd20, tries);
        waitDrain();

        applyStimulus(3'b000, 7'h00, 32'h1234_5678, 32'd3, tries);
        applyStimulus(3'b001, 7'h20, 32'h1234_5678, 32'd3, tries);
        applyStimulus(3'b101, 7'h30, 32'h0000_00F1, 32'd4, tries);
        applyStimulus(3'b001, 7'h30, 32'h8000_0001, 32'd0, tries);
        waitDrain();

        randomReady = 1'b1;
        for (int n = 0; n < 300; n++) begin
            case ($urandom_range(0, 4))
                0, 1:    f3 = 3'b001;
                2, 3:    f3 = 3'b101;
                default: f3 = 3'($urandom_range(0, 7));
            endcase
            case ($urandom_range(0, 5))
                0, 1:    f7 = 7'h00;
                2, 3:    f7 = 7'h20;
                4:       f7 = 7'h30;
                default: f7 = 7'($urandom_range(0, 127));
            endcase
            applyStimulus(f3, f7, $urandom, $urandom, tries);
            if ($urandom_range(0, 3) == 0) idleCycles($urandom_range(1, 3));
        end
        randomReady = 1'b0;
        fixedReady  = 1'b1;
        waitDrain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
